// File: rtl/imu_seq_pkg.sv
// Shared types and constants for the IMU sample sequencer.
package imu_seq_pkg;

    localparam int DATA_W_DEF = 10;

    localparam logic [1:0] CH_ACCEL1 = 2'd0;
    localparam logic [1:0] CH_ACCEL2 = 2'd1;
    localparam logic [1:0] CH_GYRO   = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP,
        PUBLISH,
        HOLD
    } state_t;

endpackage

// File: rtl/sample_period_timer.sv
// Free-running sample-period counter; one-cycle tick on the last count.
module sample_period_timer #(
    parameter int PERIOD_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // Disabling parks the count at zero so re-enable restarts a full period.
    always_ff @(posedge clk) begin
        if (reset || !enable || tick) cnt <= '0;
        else                          cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/imu_sample_sequencer.sv
// Periodic three-channel sensor read sequence with atomic publish,
// stretched data_ready, read timeout and overrun detection.
module imu_sample_sequencer
    import imu_seq_pkg::*;
#(
    parameter int PERIOD_CYCLES      = 1_000_000,
    parameter int READY_PULSE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES     = 4096,
    parameter int DATA_W             = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_errors,
    output logic              rd_req,
    output logic [1:0]        rd_addr,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] accel1,
    output logic [DATA_W-1:0] accel2,
    output logic [DATA_W-1:0] gyro,
    output logic              data_ready,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err,
    output logic [15:0]       sample_count
);

    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int HW = (READY_PULSE_CYCLES > 1) ? $clog2(READY_PULSE_CYCLES) : 1;
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(READY_PULSE_CYCLES - 1);

    if (PERIOD_CYCLES < 8 + READY_PULSE_CYCLES) begin : g_bad_period
        $error("PERIOD_CYCLES must be >= 8 + READY_PULSE_CYCLES");
    end
    if (TIMEOUT_CYCLES < 1 || READY_PULSE_CYCLES < 1) begin : g_bad_counts
        $error("TIMEOUT_CYCLES and READY_PULSE_CYCLES must be >= 1");
    end

    logic tick;

    sample_period_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    state_t            state, state_n;
    logic [1:0]        ch, ch_n;
    logic [WW-1:0]     wcnt, wcnt_n;
    logic [HW-1:0]     hcnt, hcnt_n;
    logic              cap, to_evt, pub, ovr_evt;
    logic [DATA_W-1:0] sh_a1, sh_a2, sh_gy;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        ch_n       = ch;
        wcnt_n     = wcnt;
        hcnt_n     = hcnt;
        cap        = 1'b0;
        to_evt     = 1'b0;
        pub        = 1'b0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        data_ready = 1'b0;
        busy       = (state != IDLE);
        ovr_evt    = tick && (state != IDLE);
        case (state)
            IDLE: begin
                if (tick) begin
                    state_n = REQ;
                    ch_n    = CH_ACCEL1;
                    wcnt_n  = '0;
                end
            end
            REQ: begin
                rd_req  = 1'b1;
                rd_addr = ch;
                // An ack on the final allowed cycle still counts as a good read.
                if (rd_ack || wcnt == W_LAST) begin
                    cap     = rd_ack;
                    to_evt  = !rd_ack;
                    wcnt_n  = '0;
                    state_n = (ch == CH_GYRO) ? PUBLISH : GAP;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end
            GAP: begin
                state_n = REQ;
                ch_n    = ch + 2'd1;
            end
            PUBLISH: begin
                pub     = 1'b1;
                hcnt_n  = '0;
                state_n = HOLD;
            end
            HOLD: begin
                data_ready = 1'b1;
                if (hcnt == H_LAST) state_n = IDLE;
                else                hcnt_n  = hcnt + HW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch           <= '0;
            wcnt         <= '0;
            hcnt         <= '0;
            sh_a1        <= '0;
            sh_a2        <= '0;
            sh_gy        <= '0;
            accel1       <= '0;
            accel2       <= '0;
            gyro         <= '0;
            sample_count <= '0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            ch   <= ch_n;
            wcnt <= wcnt_n;
            hcnt <= hcnt_n;
            if (cap) begin
                case (ch)
                    CH_ACCEL1: sh_a1 <= rd_data;
                    CH_ACCEL2: sh_a2 <= rd_data;
                    default:   sh_gy <= rd_data;
                endcase
            end
            // Fusion only ever sees a coherent triple: all three move on one edge.
            if (pub) begin
                accel1       <= sh_a1;
                accel2       <= sh_a2;
                gyro         <= sh_gy;
                sample_count <= sample_count + 16'd1;
            end
            if (to_evt)            timeout_err <= 1'b1;
            else if (clear_errors) timeout_err <= 1'b0;
            if (ovr_evt)           overrun <= 1'b1;
            else if (clear_errors) overrun <= 1'b0;
        end
    end

endmodule
